// File: rtl/resq_pkg.sv
// resq_pkg: shared zone/priority widths, stored-entry type and channel constants for the relief dispatcher.
package resq_pkg;
  localparam int ZONE_W = 8;
  localparam int PRIO_W = 2;
  localparam int EMERG_CH = 0;
  localparam int MAX_CH = 8;
  typedef struct packed {
    logic              live;
    logic [ZONE_W-1:0] zone;
    logic [PRIO_W-1:0] prio;
  } resq_entry_t;
  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/resq_multi_dispatch_if.sv
// resq_multi_dispatch_if: insert, cancel and serve signals between operator decode and the dispatcher.
interface resq_multi_dispatch_if #(parameter int NUM_CH = 4);
  import resq_pkg::*;
  localparam int CH_W = $clog2(NUM_CH);
  logic              ins_valid;
  logic [CH_W-1:0]   ins_ch;
  logic [ZONE_W-1:0] ins_zone;
  logic [PRIO_W-1:0] ins_prio;
  logic              ins_ready;
  logic              cancel_en;
  logic [ZONE_W-1:0] cancel_zone;
  logic              srv_req;
  logic              srv_valid;
  logic              srv_none;
  logic [CH_W-1:0]   srv_ch;
  logic [ZONE_W-1:0] srv_zone;
  logic [PRIO_W-1:0] srv_prio;
  logic              srv_boost;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_empty;
  modport master (
    output ins_valid, ins_ch, ins_zone, ins_prio, cancel_en, cancel_zone, srv_req,
    input  ins_ready, srv_valid, srv_none, srv_ch, srv_zone, srv_prio, srv_boost, ch_full, ch_empty
  );
  modport slave (
    input  ins_valid, ins_ch, ins_zone, ins_prio, cancel_en, cancel_zone, srv_req,
    output ins_ready, srv_valid, srv_none, srv_ch, srv_zone, srv_prio, srv_boost, ch_full, ch_empty
  );
endinterface

// File: rtl/resq_ch_fifo.sv
// resq_ch_fifo: one channel FIFO with zone cancel and dead-head skip; head aging/boost when RESQ_AGING_EN is defined.
module resq_ch_fifo
  import resq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter bit EMERG = 1'b0
`ifdef RESQ_AGING_EN
  , parameter int AGE_W = 8
  , parameter int AGE_THRESH = 20
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ZONE_W-1:0] zone_i,
  input  logic [PRIO_W-1:0] prio_i,
  input  logic              serve_i,
  input  logic              cancel_en_i,
  input  logic [ZONE_W-1:0] cancel_zone_i,
  output resq_entry_t       head_o,
  output logic              boost_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  resq_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             pop;
  assign head_o  = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
  // serve only targets a live head, so it never coincides with a dead-head pop
  assign pop   = serve_i || (!empty_o && !head_o.live);
  assign cnt_d = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_q + PTR_W'(pop);
      wr_q  <= wr_q + PTR_W'(push_i);
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        if (!EMERG && cancel_en_i && mem_q[i].zone == cancel_zone_i) mem_q[i].live <= 1'b0;
      if (push_i) mem_q[wr_q] <= '{live: 1'b1, zone: zone_i, prio: prio_i};
    end
`ifdef RESQ_AGING_EN
  logic [AGE_W-1:0] age_q, age_d;
  assign age_d   = (pop || empty_o) ? '0 : (head_o.live && age_q != '1) ? age_q + AGE_W'(1) : age_q;
  assign boost_o = !EMERG && age_q >= AGE_W'(AGE_THRESH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= '0;
    else age_q <= age_d;
`else
  assign boost_o = 1'b0;
`endif
endmodule

// File: rtl/resq_multi_dispatch.sv
// resq_multi_dispatch: N-channel relief dispatcher; ch0 preempts, others ranked by age boost then priority then index.
// Head aging and srv_boost are active only when RESQ_AGING_EN is defined.
module resq_multi_dispatch
  import resq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8
`ifdef RESQ_AGING_EN
  , parameter int AGE_W = 8
  , parameter int AGE_THRESH = 20
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  resq_multi_dispatch_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  resq_entry_t       head [NUM_CH];
  logic [NUM_CH-1:0] elig, boost, push, serve;
  logic [CH_W-1:0]   sel;
  logic [PRIO_W:0]   best;
  logic              found, any, hit;
  logic              srv_valid_q, srv_none_q, srv_boost_q;
  logic [CH_W-1:0]   srv_ch_q;
  logic [ZONE_W-1:0] srv_zone_q;
  logic [PRIO_W-1:0] srv_prio_q;
  assign bus.ins_ready = !bus.ch_full[bus.ins_ch];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c]  = bus.ins_valid && bus.ins_ready && bus.ins_ch == CH_W'(c);
    assign serve[c] = hit && sel == CH_W'(c);
    assign elig[c]  = head[c].live && !bus.ch_empty[c];
    resq_ch_fifo #(
      .DEPTH(DEPTH),
      .EMERG(c == EMERG_CH)
`ifdef RESQ_AGING_EN
      , .AGE_W(AGE_W)
      , .AGE_THRESH(AGE_THRESH)
`endif
    ) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push_i(push[c]),
      .zone_i(bus.ins_zone),
      .prio_i(bus.ins_prio),
      .serve_i(serve[c]),
      .cancel_en_i(bus.cancel_en),
      .cancel_zone_i(bus.cancel_zone),
      .head_o(head[c]),
      .boost_o(boost[c]),
      .full_o(bus.ch_full[c]),
      .empty_o(bus.ch_empty[c])
    );
  end
  // strict > keeps the lowest index on a {boost, prio} tie
  always_comb begin
    sel   = CH_W'(EMERG_CH);
    best  = '0;
    found = 1'b0;
    for (int i = 1; i < NUM_CH; i++)
      if (elig[i] && (!found || {boost[i], head[i].prio} > best)) begin
        sel   = CH_W'(i);
        best  = {boost[i], head[i].prio};
        found = 1'b1;
      end
    if (elig[EMERG_CH]) sel = CH_W'(EMERG_CH);
  end
  assign any = elig[EMERG_CH] || found;
  assign hit = bus.srv_req && any;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      srv_valid_q <= 1'b0;
      srv_none_q  <= 1'b0;
      srv_boost_q <= 1'b0;
      srv_ch_q    <= '0;
      srv_zone_q  <= '0;
      srv_prio_q  <= '0;
    end else begin
      srv_valid_q <= hit;
      srv_none_q  <= bus.srv_req && !any;
      srv_boost_q <= hit && boost[sel];
      srv_ch_q    <= hit ? sel : '0;
      srv_zone_q  <= hit ? head[sel].zone : '0;
      srv_prio_q  <= hit ? head[sel].prio : '0;
    end
  assign bus.srv_valid = srv_valid_q;
  assign bus.srv_none  = srv_none_q;
  assign bus.srv_boost = srv_boost_q;
  assign bus.srv_ch    = srv_ch_q;
  assign bus.srv_zone  = srv_zone_q;
  assign bus.srv_prio  = srv_prio_q;
endmodule

// File: tb/tb_resq_multi_dispatch.sv
// tb_resq_multi_dispatch: directed + random stimulus against a queue-based reference model with a serve scoreboard.
module tb_resq_multi_dispatch;
  import resq_pkg::*;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
`ifdef RESQ_AGING_EN
  localparam int AGE_THRESH = 20;
  localparam int AGE_MAX    = 255;
  int age [NUM_CH];
`endif
  typedef struct {bit live; bit [7:0] zone; bit [1:0] prio;} m_ent_t;
  typedef struct {bit none; int ch; bit [7:0] zone; bit [1:0] prio; bit boost;} exp_t;
  m_ent_t mq [NUM_CH][$];
  exp_t   expq [$];
  int     n_chk = 0;
  int     n_fail = 0;
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  always #5 clk = ~clk;
  resq_multi_dispatch_if #(.NUM_CH(NUM_CH)) bus ();
  resq_multi_dispatch #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit m_elig(int c);
    return mq[c].size() > 0 && mq[c][0].live;
  endfunction

  function automatic bit m_boost(int c);
`ifdef RESQ_AGING_EN
    return c != EMERG_CH && age[c] >= AGE_THRESH;
`else
    return 1'b0;
`endif
  endfunction

  // emergency first, then score = 10*boost + prio, earliest channel on ties; -1 when nothing live
  function automatic int m_pick();
    int best = -1;
    int bs = -1;
    if (m_elig(0)) return 0;
    for (int c = 1; c < NUM_CH; c++)
      if (m_elig(c) && 10 * int'(m_boost(c)) + int'(mq[c][0].prio) > bs) begin
        bs = 10 * int'(m_boost(c)) + int'(mq[c][0].prio);
        best = c;
      end
    return best;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
`ifdef RESQ_AGING_EN
      age[c] = 0;
`endif
    end
    expq.delete();
  endfunction

  // starts just after a negedge, ends at the next negedge
  task automatic cycle(input bit iv, input int ich, input bit [7:0] iz, input bit [1:0] ip,
                       input bit ce, input bit [7:0] cz, input bit sr);
    bit   rdy;
    int   pk;
    exp_t e;
    bit   popped [NUM_CH];
    bit   pre_ne [NUM_CH];
    bit   pre_live [NUM_CH];
    bus.ins_valid   = iv;
    bus.ins_ch      = 2'(ich);
    bus.ins_zone    = iz;
    bus.ins_prio    = ip;
    bus.cancel_en   = ce;
    bus.cancel_zone = cz;
    bus.srv_req     = sr;
    #1;
    rdy = mq[ich].size() < DEPTH;
    check("ins_ready", 32'(bus.ins_ready), 32'(rdy));
    for (int c = 0; c < NUM_CH; c++) begin
      check("ch_empty", 32'(bus.ch_empty[c]), 32'(mq[c].size() == 0));
      check("ch_full", 32'(bus.ch_full[c]), 32'(mq[c].size() == DEPTH));
      pre_ne[c]   = mq[c].size() > 0;
      pre_live[c] = pre_ne[c] && mq[c][0].live;
      popped[c]   = 1'b0;
    end
    pk = m_pick();
    if (sr) begin
      e = '{none: pk < 0, ch: 0, zone: 8'h0, prio: 2'h0, boost: 1'b0};
      if (pk >= 0) begin
        e.ch = pk;
        e.zone = mq[pk][0].zone;
        e.prio = mq[pk][0].prio;
        e.boost = m_boost(pk);
      end
      expq.push_back(e);
    end
    if (sr && pk >= 0) begin
      void'(mq[pk].pop_front());
      popped[pk] = 1'b1;
    end
    for (int c = 0; c < NUM_CH; c++)
      if (!popped[c] && pre_ne[c] && !pre_live[c]) begin
        void'(mq[c].pop_front());
        popped[c] = 1'b1;
      end
`ifdef RESQ_AGING_EN
    for (int c = 0; c < NUM_CH; c++)
      age[c] = (popped[c] || !pre_ne[c]) ? 0 : (pre_live[c] && age[c] < AGE_MAX) ? age[c] + 1 : age[c];
`endif
    if (ce)
      for (int c = 1; c < NUM_CH; c++)
        for (int k = 0; k < mq[c].size(); k++)
          if (mq[c][k].zone == cz) mq[c][k].live = 1'b0;
    if (iv && rdy) mq[ich].push_back('{live: 1'b1, zone: iz, prio: ip});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 8'h0, 2'h0, 0, 8'h0, 0);
  endtask

  task automatic ins(input int ch, input bit [7:0] z, input bit [1:0] p);
    cycle(1, ch, z, p, 0, 8'h0, 0);
  endtask

  task automatic srv();
    cycle(0, 0, 8'h0, 2'h0, 0, 8'h0, 1);
  endtask

  // each serve is checked exactly one edge after it was issued
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (expq.size() == 0) begin
      if (bus.srv_valid !== 1'b0 || bus.srv_none !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_srv: got valid=%b none=%b, required no output", bus.srv_valid, bus.srv_none);
      end
    end else begin
      e = expq.pop_front();
      check("srv_valid", 32'(bus.srv_valid), 32'(!e.none));
      check("srv_none", 32'(bus.srv_none), 32'(e.none));
      if (!e.none) begin
        check("srv_ch", 32'(bus.srv_ch), 32'(e.ch));
        check("srv_zone", 32'(bus.srv_zone), 32'(e.zone));
        check("srv_prio", 32'(bus.srv_prio), 32'(e.prio));
        check("srv_boost", 32'(bus.srv_boost), 32'(e.boost));
      end
    end
  end

  initial begin
    bus.ins_valid = 0; bus.ins_ch = '0; bus.ins_zone = '0; bus.ins_prio = '0;
    bus.cancel_en = 0; bus.cancel_zone = '0; bus.srv_req = 0;
    m_reset();
    #12;
    check("rst_srv_valid", 32'(bus.srv_valid), 0);
    check("rst_srv_none", 32'(bus.srv_none), 0);
    check("rst_ch_empty", 32'(bus.ch_empty), 32'hf);
    check("rst_ch_full", 32'(bus.ch_full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    srv();
    idle(1);
    ins(2, 8'h11, 1); ins(1, 8'h22, 3); ins(0, 8'h33, 0);
    srv(); srv(); srv();
    idle(1);
    for (int k = 0; k < 9; k++) ins(1, 8'(8'h40 + k), 2'(k));
    for (int k = 0; k < 8; k++) srv();
    idle(1);
    ins(1, 8'h05, 1); ins(1, 8'h07, 1); ins(1, 8'h05, 1); ins(0, 8'h05, 2);
    cycle(0, 0, 8'h0, 2'h0, 1, 8'h05, 0);
    srv(); srv(); srv();
    idle(1);
    ins(1, 8'h51, 0);
    idle(20);
    ins(2, 8'h52, 3);
    srv(); srv();
    idle(1);
    ins(3, 8'h61, 1); ins(3, 8'h62, 2); ins(3, 8'h63, 3);
    srv();
    bus.ins_valid = 1; bus.ins_ch = 2'd3; bus.ins_zone = 8'h64;
    #2 rst_n = 1'b0;
    #1;
    check("arst_srv_valid", 32'(bus.srv_valid), 0);
    check("arst_srv_none", 32'(bus.srv_none), 0);
    check("arst_srv_zone", 32'(bus.srv_zone), 0);
    check("arst_ch_empty", 32'(bus.ch_empty), 32'h f);
    check("arst_ch_full", 32'(bus.ch_full), 0);
    bus.ins_valid = 0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 800; k++)
      cycle($urandom_range(0, 1), $urandom_range(0, NUM_CH - 1), 8'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, 8'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0);
    idle(2);
    check("scoreboard_drained", 32'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
